// File: rtl/led_protocol_defs_pkg.sv
// Shared protocol definitions for the LED command parser: command byte codes,
// decoded command kinds and the parser state encoding.
package led_protocol_defs_pkg;

  localparam logic [7:0] CMD_SET_LED = 8'h01;
  localparam logic [7:0] CMD_FILL    = 8'h02;
  localparam logic [7:0] CMD_STREAM  = 8'h03;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_SET_LED,
    KIND_FILL,
    KIND_STREAM
  } cmdKind_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_COMMAND = 4'd1,
    ST_ADDR_HI = 4'd2,
    ST_ADDR_LO = 4'd3,
    ST_COUNT   = 4'd4,
    ST_DATA    = 4'd5,
    ST_WRITE   = 4'd6,
    ST_DONE    = 4'd7,
    ST_DISCARD = 4'd8
  } parserState_t;

  // Maps a command byte onto the kind of command it starts; unknown codes give KIND_NONE.
  function automatic cmdKind_t decodeCommand(input logic [7:0] code);
    cmdKind_t kind;
    case (code)
      CMD_SET_LED: kind = KIND_SET_LED;
      CMD_FILL:    kind = KIND_FILL;
      CMD_STREAM:  kind = KIND_STREAM;
      default:     kind = KIND_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/edge_synchroniser.sv
// Multi-flop synchroniser for an asynchronous level, with one-cycle pulses on
// the rising and falling edges of the synchronised value. Usable for any
// handshake line such as RTS or DTR.
module edge_synchroniser #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_previous;
  logic              w_synced;

  assign w_synced = r_sync[STAGES-1];

  // Shift the asynchronous input through the flop chain and remember the last synchronised level.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync     <= {STAGES{RESET_VALUE}};
      r_previous <= RESET_VALUE;
    end else begin
      r_sync     <= (r_sync << 1) | STAGES'(i_async);
      r_previous <= w_synced;
    end
  end

  assign o_rise = w_synced & ~r_previous;
  assign o_fall = ~w_synced & r_previous;

endmodule

// File: rtl/led_command_parser.sv
// LED command parser: turns UART bytes, framed by slave_select, into write
// strobes for the LED frame buffer. Supports single-LED, fill-range and
// streaming commands with write backpressure and a sticky error flag.
module led_command_parser
  import led_protocol_defs_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_BYTES    = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock_12mhz,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_ready,
  input  logic                     slave_select,
  input  logic                     write_ready,
  output logic                     perform_write,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [8*DATA_BYTES-1:0]  write_data,
  output logic                     busy,
  output logic                     error
);

  localparam int DATA_WIDTH  = 8 * DATA_BYTES;
  localparam int COUNT_WIDTH = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [COUNT_WIDTH-1:0] LAST_BYTE = COUNT_WIDTH'(DATA_BYTES - 1);

  parserState_t             r_state;
  parserState_t             w_nextState;
  cmdKind_t                 r_command;
  cmdKind_t                 w_commandKind;
  logic [7:0]               r_addrHi;
  logic [7:0]               r_remaining;
  logic [COUNT_WIDTH-1:0]   r_byteCount;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_error;
  logic                     w_ssRise;
  logic                     w_ssFall;
  logic                     w_byteValid;
  logic                     w_lastByte;
  logic                     w_writeAccepted;

  edge_synchroniser #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_ssSync (
    .i_clock (clock_12mhz),
    .i_reset (reset),
    .i_async (slave_select),
    .o_rise  (w_ssRise),
    .o_fall  (w_ssFall)
  );

  // A byte arriving together with an abort is ignored entirely.
  assign w_byteValid     = rx_data_ready & ~w_ssRise;
  assign w_lastByte      = (r_byteCount == LAST_BYTE);
  assign w_commandKind   = decodeCommand(rx_data);
  assign w_writeAccepted = (r_state == ST_WRITE) & write_ready;

  // State register.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; an abort from slave_select overrides every other transition.
  always_comb begin
    w_nextState = r_state;
    if (w_ssRise) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ssFall) w_nextState = ST_COMMAND;
        end
        ST_COMMAND: begin
          if (w_byteValid) begin
            w_nextState = (w_commandKind == KIND_NONE) ? ST_DISCARD : ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          if (w_byteValid) w_nextState = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          if (w_byteValid) w_nextState = (r_command == KIND_FILL) ? ST_COUNT : ST_DATA;
        end
        ST_COUNT: begin
          if (w_byteValid) w_nextState = ST_DATA;
        end
        ST_DATA: begin
          if (w_byteValid && w_lastByte) begin
            if (r_command == KIND_FILL && r_remaining == 8'd0) begin
              w_nextState = ST_DONE;
            end else begin
              w_nextState = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (write_ready) begin
            case (r_command)
              KIND_FILL:   w_nextState = (r_remaining == 8'd1) ? ST_DONE : ST_WRITE;
              KIND_STREAM: w_nextState = ST_DATA;
              default:     w_nextState = ST_DONE;
            endcase
          end
        end
        ST_DONE:    w_nextState = ST_DONE;
        ST_DISCARD: w_nextState = ST_DISCARD;
        default:    w_nextState = ST_IDLE;
      endcase
    end
  end

  // Outputs that follow directly from the current state.
  always_comb begin
    perform_write = (r_state == ST_WRITE);
    busy          = (r_state != ST_IDLE);
  end

  // Datapath: captures command, address, count and colour bytes, advances the address and tracks errors.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      r_command   <= KIND_NONE;
      r_addrHi    <= 8'd0;
      r_remaining <= 8'd0;
      r_byteCount <= '0;
      r_address   <= '0;
      r_data      <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_ssFall) begin
        r_error     <= 1'b0;
        r_byteCount <= '0;
      end
      case (r_state)
        ST_COMMAND: begin
          if (w_byteValid) begin
            r_command <= w_commandKind;
            if (w_commandKind == KIND_NONE) r_error <= 1'b1;
          end
        end
        ST_ADDR_HI: begin
          if (w_byteValid) r_addrHi <= rx_data;
        end
        ST_ADDR_LO: begin
          if (w_byteValid) begin
            r_address   <= ADDRESS_WIDTH'({r_addrHi, rx_data});
            r_byteCount <= '0;
          end
        end
        ST_COUNT: begin
          if (w_byteValid) r_remaining <= rx_data;
        end
        ST_DATA: begin
          if (w_byteValid) begin
            r_data      <= (r_data << 8) | DATA_WIDTH'(rx_data);
            r_byteCount <= w_lastByte ? '0 : r_byteCount + COUNT_WIDTH'(1);
          end
        end
        ST_WRITE: begin
          if (w_byteValid) r_error <= 1'b1;
          if (w_writeAccepted) begin
            r_address <= r_address + ADDRESS_WIDTH'(1);
            if (r_command == KIND_FILL) r_remaining <= r_remaining - 8'd1;
          end
        end
        ST_DONE: begin
          if (w_byteValid) r_error <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign write_address = r_address;
  assign write_data    = r_data;
  assign error         = r_error;

endmodule

// File: tb/tb_led_command_parser.sv
// Self-checking bench for led_command_parser: directed protocol scenarios plus
// randomized frames checked against a byte-level reference model of the
// command protocol.
module tb_led_command_parser;

  localparam int AW        = 9;
  localparam int DB        = 3;
  localparam int DW        = 8 * DB;
  localparam int ADDR_SPAN = 1 << AW;

  logic          clock_12mhz = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_data_ready;
  logic          slave_select;
  logic          write_ready;
  logic          perform_write;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          busy;
  logic          error;

  int totalChecks = 0;
  int badChecks   = 0;
  int obsCount    = 0;
  int readyMode   = 0;

  logic [AW-1:0] expAddrQ[$];
  logic [DW-1:0] expDataQ[$];
  logic [7:0]    frameBytes[$];
  logic [AW-1:0] mdlAddr[$];
  logic [DW-1:0] mdlData[$];
  bit            mdlError;

  always #5 clock_12mhz = ~clock_12mhz;

  led_command_parser #(
    .ADDRESS_WIDTH (AW),
    .DATA_BYTES    (DB),
    .SYNC_STAGES   (2)
  ) dut (
    .clock_12mhz   (clock_12mhz),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .slave_select  (slave_select),
    .write_ready   (write_ready),
    .perform_write (perform_write),
    .write_address (write_address),
    .write_data    (write_data),
    .busy          (busy),
    .error         (error)
  );

  // Counts one comparison and reports it when the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  // Drives one received byte as a single-cycle strobe.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clock_12mhz); #1;
    rx_data       = b;
    rx_data_ready = 1'b1;
    @(posedge clock_12mhz); #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic startFrame();
    @(posedge clock_12mhz); #1;
    slave_select = 1'b0;
    repeat (4) @(posedge clock_12mhz);
  endtask

  task automatic endFrame();
    @(posedge clock_12mhz); #1;
    slave_select = 1'b1;
    repeat (5) @(posedge clock_12mhz);
    #1;
  endtask

  task automatic pushExp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    expAddrQ.push_back(a);
    expDataQ.push_back(d);
  endtask

  // Waits, with a cycle budget, until the number of accepted writes reaches target.
  task automatic waitWrites(input int target);
    int guard;
    guard = 0;
    while (obsCount < target && guard < 400) begin
      @(negedge clock_12mhz);
      guard++;
    end
    if (obsCount < target) checkOutput("writeTimeout", obsCount, target);
  endtask

  // Every cycle the write strobe is up, address and data must equal the next expected write.
  always @(negedge clock_12mhz) begin
    if (!reset && perform_write) begin
      if (expAddrQ.size() == 0) begin
        checkOutput("unexpectedWrite", 32'(perform_write), 32'd0);
      end else begin
        checkOutput("writeAddress", 32'(write_address), 32'(expAddrQ[0]));
        checkOutput("writeData", 32'(write_data), 32'(expDataQ[0]));
        if (write_ready) begin
          void'(expAddrQ.pop_front());
          void'(expDataQ.pop_front());
        end
      end
      if (write_ready) obsCount++;
    end
  end

  // Supplies write_ready according to the current backpressure mode.
  initial begin
    write_ready = 1'b1;
    forever begin
      @(posedge clock_12mhz); #1;
      case (readyMode)
        0:       write_ready = 1'b1;
        1:       write_ready = 1'($urandom_range(0, 1));
        2:       write_ready = 1'b0;
        default: write_ready = ~write_ready;
      endcase
    end
  end

  function automatic int colourAt(input int start);
    int c;
    c = 0;
    for (int k = 0; k < DB; k++) c = c * 256 + int'(frameBytes[start + k]);
    return c;
  endfunction

  // Reference model: the writes and error a frame made of the first n bytes of frameBytes must produce.
  function automatic void modelFrame(input int n);
    int cmd;
    int addr;
    int hdr;
    int groups;
    int count;
    mdlAddr.delete();
    mdlData.delete();
    mdlError = 1'b0;
    if (n == 0) return;
    cmd = int'(frameBytes[0]);
    if (cmd < 1 || cmd > 3) begin
      mdlError = 1'b1;
      return;
    end
    if (n < 3) return;
    addr = (int'(frameBytes[1]) * 256 + int'(frameBytes[2])) % ADDR_SPAN;
    hdr  = (cmd == 2) ? 4 : 3;
    if (n < hdr) return;
    groups = (n - hdr) / DB;
    if (cmd == 3) begin
      for (int g = 0; g < groups; g++) begin
        mdlAddr.push_back(AW'((addr + g) % ADDR_SPAN));
        mdlData.push_back(DW'(colourAt(hdr + g * DB)));
      end
    end else begin
      if (groups >= 1) begin
        count = (cmd == 1) ? 1 : int'(frameBytes[3]);
        for (int i = 0; i < count; i++) begin
          mdlAddr.push_back(AW'((addr + i) % ADDR_SPAN));
          mdlData.push_back(DW'(colourAt(hdr)));
        end
      end
      if (n > hdr + DB) mdlError = 1'b1;
    end
  endfunction

  // Builds a random frame, predicts its outcome with the model and plays it to the DUT.
  task automatic runRandomFrame();
    int kind;
    int n;
    int base;
    int expWrites;
    int cut;
    int extras;
    int modes[3];
    bit expErr;
    int targets[$];
    modes[0] = 0; modes[1] = 1; modes[2] = 3;
    frameBytes.delete();
    kind = $urandom_range(0, 3);
    extras = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    if (kind == 3) begin
      frameBytes.push_back(8'($urandom_range(4, 255)));
      repeat ($urandom_range(0, 4)) frameBytes.push_back(8'($urandom));
    end else begin
      frameBytes.push_back(8'(kind + 1));
      frameBytes.push_back(8'($urandom));
      frameBytes.push_back(8'($urandom));
      if (kind == 1) frameBytes.push_back(8'($urandom_range(0, 5)));
      if (kind == 2) begin
        repeat ($urandom_range(0, 4) * DB + $urandom_range(0, DB - 1)) frameBytes.push_back(8'($urandom));
      end else begin
        repeat (DB + extras) frameBytes.push_back(8'($urandom));
      end
    end
    if ($urandom_range(0, 4) == 0 && frameBytes.size() > 1) begin
      cut = $urandom_range(1, frameBytes.size() - 1);
      while (frameBytes.size() > cut) void'(frameBytes.pop_back());
    end
    n = frameBytes.size();
    for (int i = 0; i < n; i++) begin
      modelFrame(i + 1);
      targets.push_back(mdlAddr.size());
    end
    modelFrame(n);
    for (int i = 0; i < mdlAddr.size(); i++) pushExp(mdlAddr[i], mdlData[i]);
    expErr    = mdlError;
    expWrites = mdlAddr.size();
    readyMode = modes[$urandom_range(0, 2)];
    base = obsCount;
    startFrame();
    for (int i = 0; i < n; i++) begin
      applyStimulus(frameBytes[i]);
      waitWrites(base + targets[i]);
      repeat ($urandom_range(0, 2)) @(posedge clock_12mhz);
    end
    endFrame();
    checkOutput("frameWrites", obsCount - base, expWrites);
    checkOutput("frameError", 32'(error), 32'(expErr));
    checkOutput("frameBusy", 32'(busy), 32'd0);
    readyMode = 0;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", totalChecks, badChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    reset         = 1'b1;
    rx_data       = 8'h00;
    rx_data_ready = 1'b0;
    slave_select  = 1'b1;
    repeat (3) @(posedge clock_12mhz);
    @(negedge clock_12mhz);
    checkOutput("resetPerformWrite", 32'(perform_write), 32'd0);
    checkOutput("resetAddress", 32'(write_address), 32'd0);
    checkOutput("resetData", 32'(write_data), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetError", 32'(error), 32'd0);
    @(posedge clock_12mhz); #1;
    reset = 1'b0;
    repeat (5) @(posedge clock_12mhz);

    $display("[TB] reset in the middle of a frame");
    startFrame();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h05);
    applyStimulus(8'hFF);
    @(negedge clock_12mhz);
    checkOutput("midFrameBusy", 32'(busy), 32'd1);
    @(posedge clock_12mhz); #1;
    reset        = 1'b1;
    slave_select = 1'b1;
    @(negedge clock_12mhz);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetPerformWrite", 32'(perform_write), 32'd0);
    checkOutput("midResetAddress", 32'(write_address), 32'd0);
    checkOutput("midResetData", 32'(write_data), 32'd0);
    checkOutput("midResetError", 32'(error), 32'd0);
    @(posedge clock_12mhz); #1;
    reset = 1'b0;
    repeat (5) @(posedge clock_12mhz);

    $display("[TB] SET_LED with latency check");
    pushExp(9'h005, 24'hFF8000);
    base = obsCount;
    startFrame();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h05);
    applyStimulus(8'hFF);
    applyStimulus(8'h80);
    @(posedge clock_12mhz); #1;
    rx_data       = 8'h00;
    rx_data_ready = 1'b1;
    @(negedge clock_12mhz);
    checkOutput("setBeforeLastByte", 32'(perform_write), 32'd0);
    @(posedge clock_12mhz); #1;
    rx_data_ready = 1'b0;
    @(negedge clock_12mhz);
    checkOutput("setLatency", 32'(perform_write), 32'd1);
    waitWrites(base + 1);
    repeat (2) @(posedge clock_12mhz);
    @(negedge clock_12mhz);
    checkOutput("setWrites", obsCount - base, 32'd1);
    checkOutput("setError", 32'(error), 32'd0);
    checkOutput("setDoneBusy", 32'(busy), 32'd1);

    $display("[TB] abort coinciding with a byte strobe");
    @(posedge clock_12mhz); #1;
    slave_select = 1'b1;
    @(posedge clock_12mhz); #1;
    @(posedge clock_12mhz); #1;
    rx_data       = 8'h55;
    rx_data_ready = 1'b1;
    @(posedge clock_12mhz); #1;
    rx_data_ready = 1'b0;
    repeat (3) @(posedge clock_12mhz);
    @(negedge clock_12mhz);
    checkOutput("abortWinsError", 32'(error), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);

    $display("[TB] FILL across the address wrap with toggling ready");
    pushExp(9'h1FE, 24'h112233);
    pushExp(9'h1FF, 24'h112233);
    pushExp(9'h000, 24'h112233);
    pushExp(9'h001, 24'h112233);
    readyMode = 3;
    base = obsCount;
    startFrame();
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    applyStimulus(8'hFE);
    applyStimulus(8'h04);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    waitWrites(base + 4);
    repeat (3) @(posedge clock_12mhz);
    @(negedge clock_12mhz);
    checkOutput("fillWrites", obsCount - base, 32'd4);
    checkOutput("fillError", 32'(error), 32'd0);
    endFrame();
    readyMode = 0;

    $display("[TB] STREAM with a partial trailing group");
    pushExp(9'h010, 24'h0A0B0C);
    pushExp(9'h011, 24'h0D0E0F);
    base = obsCount;
    startFrame();
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'h10);
    applyStimulus(8'h0A);
    applyStimulus(8'h0B);
    applyStimulus(8'h0C);
    waitWrites(base + 1);
    applyStimulus(8'h0D);
    applyStimulus(8'h0E);
    applyStimulus(8'h0F);
    waitWrites(base + 2);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    endFrame();
    checkOutput("streamWrites", obsCount - base, 32'd2);
    checkOutput("streamBusy", 32'(busy), 32'd0);
    checkOutput("streamError", 32'(error), 32'd0);

    $display("[TB] unknown command byte");
    base = obsCount;
    startFrame();
    applyStimulus(8'h7F);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    @(negedge clock_12mhz);
    checkOutput("badCmdError", 32'(error), 32'd1);
    checkOutput("badCmdBusy", 32'(busy), 32'd1);
    endFrame();
    checkOutput("badCmdWrites", obsCount - base, 32'd0);
    checkOutput("badCmdErrorSticky", 32'(error), 32'd1);

    $display("[TB] FILL with zero count");
    base = obsCount;
    startFrame();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h20);
    applyStimulus(8'h00);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    repeat (3) @(posedge clock_12mhz);
    @(negedge clock_12mhz);
    checkOutput("fillZeroError", 32'(error), 32'd0);
    checkOutput("fillZeroBusy", 32'(busy), 32'd1);
    endFrame();
    checkOutput("fillZeroWrites", obsCount - base, 32'd0);

    $display("[TB] overrun while a STREAM write is stalled");
    readyMode = 2;
    pushExp(9'h030, 24'hA1A2A3);
    pushExp(9'h031, 24'hB1B2B3);
    base = obsCount;
    startFrame();
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'h30);
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    repeat (2) @(posedge clock_12mhz);
    @(negedge clock_12mhz);
    checkOutput("stallPerformWrite", 32'(perform_write), 32'd1);
    checkOutput("stallErrorBefore", 32'(error), 32'd0);
    applyStimulus(8'h77);
    @(negedge clock_12mhz);
    checkOutput("overrunError", 32'(error), 32'd1);
    checkOutput("overrunData", 32'(write_data), 32'hA1A2A3);
    checkOutput("overrunAddress", 32'(write_address), 32'h030);
    checkOutput("overrunPerformWrite", 32'(perform_write), 32'd1);
    readyMode = 0;
    waitWrites(base + 1);
    applyStimulus(8'hB1);
    applyStimulus(8'hB2);
    applyStimulus(8'hB3);
    waitWrites(base + 2);
    endFrame();
    checkOutput("overrunWrites", obsCount - base, 32'd2);
    checkOutput("overrunErrorSticky", 32'(error), 32'd1);

    $display("[TB] randomized frames");
    for (int f = 0; f < 30; f++) runRandomFrame();

    repeat (3) @(posedge clock_12mhz);
    checkOutput("leftoverExpected", expAddrQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
